// File: rtl/val2_shifter_iter.sv
// Iterative ARM shifter-operand unit: builds Val2 and the shifter carry-out by
// shifting a work register up to SHIFT_PER_CYCLE positions per clock.
module val2_shifter_iter #(
    parameter int SHIFT_PER_CYCLE = 4,
    parameter bit MEM_SIGN_EXT    = 1'b1,
    parameter bit RRX_EN          = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mem_inst,
    input  logic        imm,
    input  logic [31:0] val_rm,
    input  logic [11:0] shift_operand,
    input  logic        carry_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] val2,
    output logic        carry_out
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // Low two op bits match the instruction's shift-type field.
    localparam logic [2:0] OP_LSL = 3'd0;
    localparam logic [2:0] OP_LSR = 3'd1;
    localparam logic [2:0] OP_ASR = 3'd2;
    localparam logic [2:0] OP_ROR = 3'd3;
    localparam logic [2:0] OP_RRX = 3'd4;

    localparam logic [5:0] SPC = 6'(SHIFT_PER_CYCLE);

    logic [1:0]  state;
    logic [5:0]  rem;
    logic [2:0]  op;
    logic [31:0] work;
    logic        carry_w;

    logic [31:0] dec_work;
    logic [5:0]  dec_rem;
    logic [2:0]  dec_op;
    logic [5:0]  step_amt;
    logic [32:0] step_res;

    // One shift step of s (1..32) positions; returns {carry, result}.
    function automatic logic [32:0] shift_step(input logic [31:0] w, input logic c,
                                               input logic [2:0] kind, input logic [5:0] s);
        logic [4:0]  s5;
        logic [31:0] r;
        logic        co;
        s5 = s[4:0];
        r  = w;
        co = c;
        case (kind)
            OP_LSL: begin r = w << s; co = w[5'd0 - s5]; end
            OP_LSR: begin r = w >> s; co = w[s5 - 5'd1]; end
            OP_ASR: begin r = $unsigned($signed(w) >>> s); co = w[s5 - 5'd1]; end
            OP_ROR: begin r = (w >> s) | (w << (6'd32 - s)); co = r[31]; end
            OP_RRX: begin r = {c, w[31:1]}; co = w[0]; end
            default: begin r = w; co = c; end
        endcase
        return {co, r};
    endfunction

    always_comb begin
        dec_work = val_rm;
        dec_rem  = 6'd0;
        dec_op   = OP_LSL;
        if (mem_inst) begin
            dec_work = MEM_SIGN_EXT ? {{20{shift_operand[11]}}, shift_operand}
                                    : {20'd0, shift_operand};
        end else if (imm) begin
            dec_work = {24'd0, shift_operand[7:0]};
            dec_op   = OP_ROR;
            dec_rem  = {1'b0, shift_operand[11:8], 1'b0};
        end else begin
            dec_op = {1'b0, shift_operand[6:5]};
            case (shift_operand[6:5])
                2'b00: dec_rem = {1'b0, shift_operand[11:7]};
                // A zero amount encodes a full 32-bit shift for LSR/ASR.
                2'b01, 2'b10: dec_rem = (shift_operand[11:7] == 5'd0) ? 6'd32
                                                                       : {1'b0, shift_operand[11:7]};
                default: begin
                    if (shift_operand[11:7] != 5'd0) begin
                        dec_rem = {1'b0, shift_operand[11:7]};
                    end else if (RRX_EN) begin
                        dec_op  = OP_RRX;
                        dec_rem = 6'd1;
                    end
                end
            endcase
        end
    end

    assign step_amt = (rem < SPC) ? rem : SPC;
    assign step_res = shift_step(work, carry_w, op, step_amt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rem       <= 6'd0;
            op        <= OP_LSL;
            val2      <= 32'd0;
            carry_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SHIFT;
                        rem   <= dec_rem;
                        op    <= dec_op;
                    end
                end
                SHIFT: begin
                    if (rem == 6'd0) begin
                        state     <= DONE;
                        val2      <= work;
                        carry_out <= carry_w;
                    end else begin
                        rem <= rem - step_amt;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath registers carry no reset; they are always loaded on accept.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            work    <= dec_work;
            carry_w <= carry_in;
        end else if (state == SHIFT && rem != 6'd0) begin
            {carry_w, work} <= step_res;
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_val2_shifter_iter.sv
// Directed bench for val2_shifter_iter with SHIFT_PER_CYCLE=4; a second instance
// with zero-extended memory offsets shares the inputs.
module tb_val2_shifter_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mem_inst = 1'b0;
    logic        imm = 1'b0;
    logic [31:0] val_rm = 32'd0;
    logic [11:0] shift_operand = 12'd0;
    logic        carry_in = 1'b0;
    logic        busy, done, carry_out;
    logic [31:0] val2;
    logic        busy_z, done_z, carry_out_z;
    logic [31:0] val2_z;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    val2_shifter_iter #(.SHIFT_PER_CYCLE(4), .MEM_SIGN_EXT(1'b1), .RRX_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .mem_inst(mem_inst), .imm(imm),
        .val_rm(val_rm), .shift_operand(shift_operand), .carry_in(carry_in),
        .busy(busy), .done(done), .val2(val2), .carry_out(carry_out));

    val2_shifter_iter #(.SHIFT_PER_CYCLE(4), .MEM_SIGN_EXT(1'b0), .RRX_EN(1'b1)) dut_z (
        .clk(clk), .rst(rst), .start(start), .mem_inst(mem_inst), .imm(imm),
        .val_rm(val_rm), .shift_operand(shift_operand), .carry_in(carry_in),
        .busy(busy_z), .done(done_z), .val2(val2_z), .carry_out(carry_out_z));

    always @(negedge clk) if (done) done_cnt++;

    // Issue one operation from IDLE, wait for done, then step back into IDLE.
    task automatic run_op(input logic m, input logic i, input logic [31:0] rm,
                          input logic [11:0] so, input logic ci,
                          output int lat, output bit busy_ok);
        mem_inst = m; imm = i; val_rm = rm; shift_operand = so; carry_in = ci;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        busy_ok = busy;
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (!done && !busy) busy_ok = 1'b0;
        end
        if (done && busy) busy_ok = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
        n_checks++; if (val2 !== 32'd0) begin n_fail++; $display("FAIL reset_val2 got %h exp 0", val2); end
        n_checks++; if (carry_out !== 1'b0) begin n_fail++; $display("FAIL reset_carry got %b exp 0", carry_out); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_imm();
        logic [11:0] so_t [3] = '{12'h4FF, 12'h0AB, 12'h103};
        logic        ci_t [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] ev_t [3] = '{32'hFF000000, 32'h000000AB, 32'hC0000000};
        logic        ec_t [3] = '{1'b1, 1'b1, 1'b1};
        int          el_t [3] = '{4, 2, 3};
        int lat;
        bit bok;
        for (int k = 0; k < 3; k++) begin
            run_op(1'b0, 1'b1, 32'h5A5A5A5A, so_t[k], ci_t[k], lat, bok);
            n_checks++; if (val2 !== ev_t[k]) begin n_fail++; $display("FAIL imm%0d_val2 got %h exp %h", k, val2, ev_t[k]); end
            n_checks++; if (carry_out !== ec_t[k]) begin n_fail++; $display("FAIL imm%0d_carry got %b exp %b", k, carry_out, ec_t[k]); end
            n_checks++; if (lat != el_t[k]) begin n_fail++; $display("FAIL imm%0d_latency got %0d exp %0d", k, lat, el_t[k]); end
            n_checks++; if (!bok) begin n_fail++; $display("FAIL imm%0d_busy got 0 exp 1 while shifting", k); end
        end
    endtask

    task automatic test_reg_shift();
        logic [11:0] so_t [9] = '{12'h020, 12'h200, 12'h240, 12'h040, 12'h460,
                                  12'h000, 12'h280, 12'h1A0, 12'h0A0};
        logic [31:0] rm_t [9] = '{32'h80000001, 32'hF0000000, 32'h80000010, 32'h80000000,
                                  32'h123456F8, 32'hDEADBEEF, 32'h0C000001, 32'h00000015,
                                  32'h00000002};
        logic        ci_t [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] ev_t [9] = '{32'h00000000, 32'h00000000, 32'hF8000001, 32'hFFFFFFFF,
                                  32'hF8123456, 32'hDEADBEEF, 32'h80000020, 32'h00000002,
                                  32'h00000001};
        logic        ec_t [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int          el_t [9] = '{10, 3, 3, 10, 4, 2, 4, 3, 3};
        int lat;
        bit bok;
        for (int k = 0; k < 9; k++) begin
            run_op(1'b0, 1'b0, rm_t[k], so_t[k], ci_t[k], lat, bok);
            n_checks++; if (val2 !== ev_t[k]) begin n_fail++; $display("FAIL reg%0d_val2 got %h exp %h", k, val2, ev_t[k]); end
            n_checks++; if (carry_out !== ec_t[k]) begin n_fail++; $display("FAIL reg%0d_carry got %b exp %b", k, carry_out, ec_t[k]); end
            n_checks++; if (lat != el_t[k]) begin n_fail++; $display("FAIL reg%0d_latency got %0d exp %0d", k, lat, el_t[k]); end
        end
    endtask

    task automatic test_rrx();
        int lat;
        bit bok;
        run_op(1'b0, 1'b0, 32'h00000003, 12'h060, 1'b1, lat, bok);
        n_checks++; if (val2 !== 32'h80000001) begin n_fail++; $display("FAIL rrx_val2 got %h exp 80000001", val2); end
        n_checks++; if (carry_out !== 1'b1) begin n_fail++; $display("FAIL rrx_carry got %b exp 1", carry_out); end
        n_checks++; if (lat != 3) begin n_fail++; $display("FAIL rrx_latency got %0d exp 3", lat); end
    endtask

    task automatic test_mem();
        int lat;
        bit bok;
        run_op(1'b1, 1'b1, 32'hDEADBEEF, 12'hFFC, 1'b1, lat, bok);
        n_checks++; if (val2 !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL mem_sext_val2 got %h exp FFFFFFFC", val2); end
        n_checks++; if (val2_z !== 32'h00000FFC) begin n_fail++; $display("FAIL mem_zext_val2 got %h exp 00000FFC", val2_z); end
        n_checks++; if (carry_out !== 1'b1) begin n_fail++; $display("FAIL mem_carry got %b exp 1", carry_out); end
        n_checks++; if (carry_out_z !== 1'b1) begin n_fail++; $display("FAIL mem_zext_carry got %b exp 1", carry_out_z); end
        n_checks++; if (lat != 2) begin n_fail++; $display("FAIL mem_latency got %0d exp 2", lat); end
        run_op(1'b1, 1'b0, 32'h0, 12'h7FF, 1'b0, lat, bok);
        n_checks++; if (val2 !== 32'h000007FF) begin n_fail++; $display("FAIL mem_pos_val2 got %h exp 000007FF", val2); end
        n_checks++; if (carry_out !== 1'b0) begin n_fail++; $display("FAIL mem_pos_carry got %b exp 0", carry_out); end
    endtask

    task automatic test_back_to_back();
        int base;
        int cyc;
        base = done_cnt;
        mem_inst = 1'b0; imm = 1'b0; val_rm = 32'h00001234; shift_operand = 12'h200; carry_in = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        val_rm = 32'hFFFFFFFF; shift_operand = 12'h020; carry_in = 1'b1;
        cyc = 1;
        while (!done && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        n_checks++; if (done_cnt - base != 1) begin n_fail++; $display("FAIL b2b_done_count got %0d exp 1", done_cnt - base); end
        n_checks++; if (cyc != 3) begin n_fail++; $display("FAIL b2b_latency got %0d exp 3", cyc); end
        n_checks++; if (val2 !== 32'h00012340) begin n_fail++; $display("FAIL b2b_val2 got %h exp 00012340", val2); end
        n_checks++; if (carry_out !== 1'b0) begin n_fail++; $display("FAIL b2b_carry got %b exp 0", carry_out); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end got %b exp 0", busy); end
    endtask

    task automatic test_abort();
        int base;
        base = done_cnt;
        mem_inst = 1'b0; imm = 1'b0; val_rm = 32'h80000001; shift_operand = 12'h020; carry_in = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b exp 0", busy); end
        n_checks++; if (val2 !== 32'd0) begin n_fail++; $display("FAIL abort_val2 got %h exp 0", val2); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done got %b exp 0", done); end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        n_checks++; if (done_cnt != base) begin n_fail++; $display("FAIL abort_no_done got %0d pulses exp 0", done_cnt - base); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle_busy got %b exp 0", busy); end
    endtask

    initial begin
        test_reset();
        test_imm();
        test_reg_shift();
        test_rrx();
        test_mem();
        test_back_to_back();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
